muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer that produces the HI/LO results for the multicycle CPU's mult/div instructions.
- The control unit pulses start with operands taken from the A and B registers, then holds its own state machine until done.
- HI/LO outputs feed the write-data mux of the register bank (mfhi/mflo path).
- One shared radix-2 shift/add-subtract datapath serves both operations, sequenced by an internal FSM.

---
 rtl/muldiv_seq.sv | 214 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed multiply / divide sequencer that produces the HI/LO
// results for the multicycle CPU's mult/div instructions. One radix-2
// shift/add-subtract datapath serves both operations. It takes WIDTH iterations,
// with a load cycle before them and a sign-fix cycle after them.
//
// Optional feature: define MULDIV_UNSIGNED_EN to add i_op_unsigned (multu/divu).
// When the macro is undefined, every operation is signed and the port is absent.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous, active-high reset
//   i_start        request pulse, sampled only in IDLE
//   i_op           0 = multiply, 1 = divide
//   i_op_unsigned  (MULDIV_UNSIGNED_EN only) treat operands as unsigned
//   i_a_in         multiplicand / dividend
//   i_b_in         multiplier / divisor
//   o_busy         high whenever the FSM is not in IDLE
//   o_done         single-cycle completion pulse
//   o_div_zero     divide-by-zero flag, held until the next accepted start
//   o_hi_out       product high half / remainder
//   o_lo_out       product low half / quotient
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | form magnitudes and result signs, clear accumulator
// ITER  | one shift-add / restoring shift-subtract step per cycle
// FIX   | apply sign correction, write HI/LO
// DONE  | done pulse, then return to IDLE
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_op,
`ifdef MULDIV_UNSIGNED_EN
  input  logic             i_op_unsigned,
`endif
  input  logic [WIDTH-1:0] i_a_in,
  input  logic [WIDTH-1:0] i_b_in,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_zero,
  output logic [WIDTH-1:0] o_hi_out,
  output logic [WIDTH-1:0] o_lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic              r_op;
  logic              r_uns;
  logic [WIDTH-1:0]  r_m;        // multiplicand / divisor magnitude
  logic [WIDTH-1:0]  r_q;        // multiplier shifting out / quotient shifting in
  logic [WIDTH:0]    r_acc;      // partial product high half / partial remainder
  logic              r_neg_lo;
  logic              r_neg_hi;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_div_zero;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;

  logic              w_start_uns;
  logic              w_sa;
  logic              w_sb;
  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic              w_b_zero;
  logic [WIDTH:0]    w_rem_shift;
  logic [WIDTH:0]    w_opa;
  logic [WIDTH:0]    w_opb;
  logic [WIDTH+1:0]  w_sum;
  logic              w_no_borrow;
  logic [WIDTH:0]    w_mul_t;
  logic [WIDTH:0]    w_acc_next;
  logic [WIDTH-1:0]  w_q_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]  w_quo_fix;
  logic [WIDTH-1:0]  w_rem_fix;

`ifdef MULDIV_UNSIGNED_EN
  assign w_start_uns = i_op_unsigned;
`else
  assign w_start_uns = 1'b0;
`endif

  assign w_sa     = r_a[WIDTH-1] & ~r_uns;
  assign w_sb     = r_b[WIDTH-1] & ~r_uns;
  // Negating -2^(W-1) gives 2^(W-1), and that value still fits as an unsigned magnitude.
  assign w_mag_a  = w_sa ? (~r_a + 1'b1) : r_a;
  assign w_mag_b  = w_sb ? (~r_b + 1'b1) : r_b;
  assign w_b_zero = (r_b == '0);

  // Shared adder. A multiply adds the multiplicand to the accumulator. A divide
  // subtracts the divisor from the shifted remainder. The subtraction is done as
  // a + ~b + 1, so a carry out of the top bit means no borrow, which means the
  // trial subtraction succeeded.
  assign w_rem_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_opa       = r_op ? w_rem_shift : r_acc;
  assign w_opb       = r_op ? ~{1'b0, r_m} : {1'b0, r_m};
  assign w_sum       = {1'b0, w_opa} + {1'b0, w_opb} + {{(WIDTH+1){1'b0}}, r_op};
  assign w_no_borrow = w_sum[WIDTH+1];

  assign w_mul_t    = r_q[0] ? w_sum[WIDTH:0] : r_acc;
  assign w_acc_next = r_op ? (w_no_borrow ? w_sum[WIDTH:0] : w_rem_shift)
                           : {1'b0, w_mul_t[WIDTH:1]};
  assign w_q_next   = r_op ? {r_q[WIDTH-2:0], w_no_borrow}
                           : {w_mul_t[0], r_q[WIDTH-1:1]};

  assign w_prod     = {r_acc[WIDTH-1:0], r_q};
  assign w_prod_fix = r_neg_hi ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = r_neg_lo ? (~r_q + 1'b1) : r_q;
  assign w_rem_fix  = r_neg_hi ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= 1'b0;
      r_uns      <= 1'b0;
      r_m        <= '0;
      r_q        <= '0;
      r_acc      <= '0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_a        <= i_a_in;
            r_b        <= i_b_in;
            r_op       <= i_op;
            r_uns      <= w_start_uns;
            r_busy     <= 1'b1;
            r_div_zero <= 1'b0;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_m      <= r_op ? w_mag_b : w_mag_a;
          r_q      <= r_op ? w_mag_a : w_mag_b;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_neg_lo <= w_sa ^ w_sb;
          // The remainder follows the sign of the dividend. The product uses one sign for both halves.
          r_neg_hi <= r_op ? w_sa : (w_sa ^ w_sb);
          if (r_op && w_b_zero) begin
            r_div_zero <= 1'b1;
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_acc <= w_acc_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_op) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_fix[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;
  assign o_hi_out   = r_hi;
  assign o_lo_out   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized plus directed bench for muldiv_seq. The reference model computes HI/LO
// with plain integer *, / and % on 64-bit values. It also tracks the
// divide-by-zero flag and the retained HI/LO values.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic        op_u;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_op         (op),
`ifdef MULDIV_UNSIGNED_EN
    .i_op_unsigned(op_u),
`endif
    .i_a_in       (a_in),
    .i_b_in       (b_in),
    .o_busy       (busy),
    .o_done       (done),
    .o_div_zero   (div_zero),
    .o_hi_out     (hi_out),
    .o_lo_out     (lo_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: updates the model's HI/LO/div_zero for one accepted operation.
  task automatic model(input logic mop, input logic uns, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    logic [63:0] qv, rv;
    if (mop == 1'b0) begin
      if (uns) p = {32'b0, a} * {32'b0, b};
      else begin
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        p  = sa * sb;
      end
      m_hi = p[63:32];
      m_lo = p[31:0];
      m_dz = 1'b0;
    end else if (b == 32'd0) begin
      m_dz = 1'b1;
    end else begin
      if (uns) begin
        m_lo = a / b;
        m_hi = a % b;
      end else begin
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        sq = sa / sb;
        sr = sa % sb;
        qv = sq;
        rv = sr;
        m_lo = qv[31:0];
        m_hi = rv[31:0];
      end
      m_dz = 1'b0;
    end
  endtask

  // Caller must be at a falling edge. Returns at the falling edge one cycle after done.
  task automatic run_op(input logic mop, input logic uns, input logic [31:0] a, input logic [31:0] b,
                        input int repulse_at, input bit start_in_done, input string tag);
    int          cnt = 0;
    bit          seen = 0;
    int          busy_bad = 0;
    int          stab_bad = 0;
    logic [31:0] prev_hi = m_hi;
    logic [31:0] prev_lo = m_lo;
    int          exp_lat;
    start = 1'b1;
    op    = mop;
    op_u  = uns;
    a_in  = a;
    b_in  = b;
    exp_lat = (mop && b == 32'd0) ? 2 : 35;
    while (!seen && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (done) seen = 1;
      else begin
        if (!busy) busy_bad++;
        if (hi_out !== prev_hi || lo_out !== prev_lo) stab_bad++;
      end
      if (!seen) begin
        if (repulse_at != 0 && cnt == repulse_at) begin
          start = 1'b1;
          op    = ~mop;
          a_in  = a ^ 32'h5A5A_0F0F;
          b_in  = b + 32'd17;
        end else begin
          start = 1'b0;
        end
      end
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(cnt), 64'(exp_lat));
    model(mop, uns, a, b);
    chk({tag, "_busy_during"}, 64'(busy_bad), 64'd0);
    chk({tag, "_hilo_stable"}, 64'(stab_bad), 64'd0);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    chk({tag, "_hi"}, 64'(hi_out), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo_out), 64'(m_lo));
    chk({tag, "_div_zero"}, 64'(div_zero), 64'(m_dz));
    if (start_in_done) begin
      start = 1'b1;
      op    = 1'b0;
      a_in  = 32'h0000_0009;
      b_in  = 32'h0000_0009;
    end else begin
      start = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h8000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'd1;
      3: v = 32'd0;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    op_u  = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_div_zero", 64'(div_zero), 64'd0);
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 0, "mul_7_m3");
    chk("mul_7_m3_hi_const", 64'(hi_out), 64'hFFFF_FFFF);
    chk("mul_7_m3_lo_const", 64'(lo_out), 64'hFFFF_FFEB);
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_m7_2");
    chk("div_m7_2_lo_const", 64'(lo_out), 64'hFFFF_FFFD);
    chk("div_m7_2_hi_const", 64'(hi_out), 64'hFFFF_FFFF);

    run_op(1'b1, 1'b0, 32'h0000_0451, 32'h20, 0, 0, "div_prep");
    run_op(1'b1, 1'b0, 32'd5, 32'd0, 0, 0, "div_by_zero");
    chk("dz_hi_kept", 64'(hi_out), 64'h11);
    chk("dz_lo_kept", 64'(lo_out), 64'h22);
    chk("dz_flag_held", 64'(div_zero), 64'd1);
    run_op(1'b0, 1'b0, 32'd3, 32'd5, 0, 0, "dz_clear");

    run_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, 0, "mul_min_min");
    chk("mul_min_min_hi_const", 64'(hi_out), 64'h4000_0000);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_min_m1");
    chk("div_min_m1_lo_const", 64'(lo_out), 64'h8000_0000);
    chk("div_min_m1_hi_const", 64'(hi_out), 64'h0);

    run_op(1'b0, 1'b0, 32'h0001_2345, 32'hFFFE_5678, 8, 1, "hs_repulse");
    run_op(1'b1, 1'b0, 32'hFFFF_0000, 32'd300, 0, 0, "hs_back2back");

    start = 1'b1;
    op    = 1'b1;
    a_in  = 32'd1000;
    b_in  = 32'd7;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi_out), 64'd0);
    chk("midrst_lo", 64'(lo_out), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_done", 64'(done), 64'd0);
    end
    run_op(1'b0, 1'b0, 32'd3, 32'd4, 0, 0, "mul_3_4");
    chk("mul_3_4_lo_const", 64'(lo_out), 64'd12);

    for (int i = 0; i < 40; i++) begin
      logic        rop;
      logic        runs;
      logic [31:0] ra;
      logic [31:0] rb;
      rop  = 1'($urandom_range(0, 1));
`ifdef MULDIV_UNSIGNED_EN
      runs = 1'($urandom_range(0, 1));
`else
      runs = 1'b0;
`endif
      ra = pick();
      rb = pick();
      run_op(rop, runs, ra, rb, 0, 0, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
